// File: rtl/mac_v5.sv
`default_nettype none
// ============================================================================
// Module      : mac_v5
// Description : Signed multiply-accumulate over KERNEL_SIZE*KERNEL_SIZE beats.
//               Each group of accepted operand pairs is summed, the bias sampled
//               on the last beat is added, and the result is held with a
//               valid/ready handshake until the consumer takes it.
// Revision    : 1.0 - initial release
// ============================================================================
module mac_v5 #(
    parameter int INPUT_BIT_RESOLUTION  = 8,
    parameter int OUTPUT_BIT_RESOLUTION = 32,
    parameter int KERNEL_SIZE           = 3
) (
    input  logic                                     clk_i,
    input  logic                                     rst_ni,
    input  logic                                     mac_fin_and_kernel_valid_i,
    input  logic signed [INPUT_BIT_RESOLUTION-1:0]   mac_fin_data_i,
    input  logic signed [INPUT_BIT_RESOLUTION-1:0]   mac_kernel_data_i,
    input  logic signed [OUTPUT_BIT_RESOLUTION-1:0]  mac_kernel_bias_i,
    output logic                                     mac_valid_o,
    output logic signed [OUTPUT_BIT_RESOLUTION-1:0]  mac_data_o,
    input  logic                                     mac_ready_i
);

    // Beats per group and the counter width needed to hold the value N itself
    localparam int c_N     = KERNEL_SIZE * KERNEL_SIZE;
    localparam int c_CNT_W = $clog2(c_N + 1);
    localparam int c_PRD_W = 2 * INPUT_BIT_RESOLUTION;

    localparam logic [0:0] c_ST_ACCUM  = 1'b0;
    localparam logic [0:0] c_ST_OUTPUT = 1'b1;

    logic [0:0]                              r_state;
    logic        [c_CNT_W-1:0]               r_cnt;
    logic signed [OUTPUT_BIT_RESOLUTION-1:0] r_acc;
    logic signed [OUTPUT_BIT_RESOLUTION-1:0] r_data;
    logic                                    r_valid;

    logic signed [c_PRD_W-1:0]               w_product;
    logic signed [OUTPUT_BIT_RESOLUTION-1:0] w_product_ext;
    logic signed [OUTPUT_BIT_RESOLUTION-1:0] w_acc_next;
    logic                                    w_last_beat;

    // Full-precision signed product, sign-extended into the accumulator width
    assign w_product     = mac_fin_data_i * mac_kernel_data_i;
    assign w_product_ext = OUTPUT_BIT_RESOLUTION'(w_product);
    assign w_acc_next    = r_acc + w_product_ext;
    assign w_last_beat   = (r_cnt == c_CNT_W'(c_N - 1));

    // Group accumulation, result registration and output handshake
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state <= c_ST_ACCUM;
            r_cnt   <= '0;
            r_acc   <= '0;
            r_data  <= '0;
            r_valid <= 1'b0;
        end else begin
            case (r_state)
                c_ST_ACCUM: begin
                    if (mac_fin_and_kernel_valid_i) begin
                        r_cnt <= r_cnt + c_CNT_W'(1);
                        if (w_last_beat) begin
                            // Bias only matters on the closing beat of a group
                            r_data  <= w_acc_next + mac_kernel_bias_i;
                            r_valid <= 1'b1;
                            r_state <= c_ST_OUTPUT;
                        end else begin
                            r_acc <= w_acc_next;
                        end
                    end
                end
                c_ST_OUTPUT: begin
                    // Operands offered here are dropped; only the handshake matters
                    if (mac_ready_i) begin
                        r_valid <= 1'b0;
                        r_cnt   <= '0;
                        r_acc   <= '0;
                        r_state <= c_ST_ACCUM;
                    end
                end
                default: begin
                    r_state <= c_ST_ACCUM;
                    r_cnt   <= '0;
                    r_acc   <= '0;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

    assign mac_valid_o = r_valid;
    assign mac_data_o  = r_data;

endmodule
`default_nettype wire

// File: tb/tb_mac_v5.sv
`default_nettype none
// ============================================================================
// Module      : tb_mac_v5
// Description : Self-checking bench for mac_v5 with a group-level reference
//               model, directed literal cases and randomized traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mac_v5;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               valid = 1'b0;
    logic signed [7:0]  fin = '0;
    logic signed [7:0]  kern = '0;
    logic signed [31:0] bias = '0;
    logic               ready = 1'b0;
    logic               mac_valid;
    logic signed [31:0] mac_data;

    int n_checks = 0;
    int n_pass   = 0;
    bit checking = 1'b0;

    // Reference model: a group is a list of accepted products plus a bias
    bit          exp_valid = 1'b0;
    logic [31:0] exp_data  = '0;
    longint      grp_sum   = 0;
    int          grp_beats = 0;

    mac_v5 #(
        .INPUT_BIT_RESOLUTION (8),
        .OUTPUT_BIT_RESOLUTION(32),
        .KERNEL_SIZE          (3)
    ) dut (
        .clk_i                     (clk),
        .rst_ni                    (rst_n),
        .mac_fin_and_kernel_valid_i(valid),
        .mac_fin_data_i            (fin),
        .mac_kernel_data_i         (kern),
        .mac_kernel_bias_i         (bias),
        .mac_valid_o               (mac_valid),
        .mac_data_o                (mac_data),
        .mac_ready_i               (ready)
    );

    always #5 clk = ~clk;

    // Model update at each rising edge from the inputs driven on the prior falling edge
    always @(posedge clk) begin
        if (!rst_n) begin
            exp_valid = 1'b0;
            exp_data  = '0;
            grp_sum   = 0;
            grp_beats = 0;
        end else if (exp_valid) begin
            if (ready) begin
                exp_valid = 1'b0;
                grp_sum   = 0;
                grp_beats = 0;
            end
        end else if (valid) begin
            grp_sum   = grp_sum + longint'(fin) * longint'(kern);
            grp_beats = grp_beats + 1;
            if (grp_beats == 9) begin
                exp_data  = 32'(grp_sum + longint'(bias));
                exp_valid = 1'b1;
            end
        end
    end

    // Per-cycle comparison of DUT outputs against the model
    always @(posedge clk) begin
        #1;
        if (checking) begin
            n_checks = n_checks + 1;
            if (mac_valid === exp_valid && mac_data === exp_data)
                n_pass = n_pass + 1;
            else
                $display("FAIL cycle_compare @%0t: got valid=%0b data=%0d, expected valid=%0b data=%0d",
                         $time, mac_valid, mac_data, exp_valid, $signed(exp_data));
        end
    end

    task automatic step(input bit rs, input bit v, input bit r, input int f, input int w, input int b);
        @(negedge clk);
        rst_n = rs;
        valid = v;
        ready = r;
        fin   = f[7:0];
        kern  = w[7:0];
        bias  = b;
        @(posedge clk);
    endtask

    // Pins both the DUT and the model to a hand-computed value
    task automatic check_lit(input string name, input bit v, input int d);
        #2;
        n_checks = n_checks + 1;
        if (mac_valid === v && mac_data === d)
            n_pass = n_pass + 1;
        else
            $display("FAIL %s: got valid=%0b data=%0d, required valid=%0b data=%0d",
                     name, mac_valid, mac_data, v, d);
        n_checks = n_checks + 1;
        if (exp_valid == v && exp_data == d)
            n_pass = n_pass + 1;
        else
            $display("FAIL %s_model: got valid=%0b data=%0d, required valid=%0b data=%0d",
                     name, exp_valid, $signed(exp_data), v, d);
    endtask

    task automatic group(input int f, input int w, input int b, input bit r, input bit bubbles);
        for (int i = 0; i < 9; i++) begin
            if (bubbles) step(1, 0, r, 77, 77, 999);
            step(1, 1, r, f, w, (i == 8) ? b : 12345);
        end
    endtask

    initial begin
        // Reset state
        step(0, 1, 1, 5, 5, 5);
        checking = 1'b1;
        step(0, 1, 1, 5, 5, 5);
        check_lit("reset_state", 0, 0);

        // Simple group, result latency and release
        group(1, 1, 5, 1, 0);
        check_lit("ones_bias5", 1, 14);
        step(1, 0, 1, 0, 0, 0);
        check_lit("ones_release", 0, 14);

        // Extreme operands
        group(-128, -128, -4096, 1, 0);
        check_lit("neg_neg", 1, 143360);
        step(1, 0, 1, 0, 0, 0);
        group(-128, 127, 4096, 1, 0);
        check_lit("neg_pos", 1, -142208);
        step(1, 0, 1, 0, 0, 0);

        // Bubbles between beats are not counted
        group(2, 3, 0, 1, 1);
        check_lit("bubbles", 1, 54);
        step(1, 0, 1, 0, 0, 0);

        // Backpressure: result held, offered beats ignored
        group(1, 2, 0, 0, 0);
        check_lit("hold_first", 1, 18);
        for (int i = 0; i < 5; i++) begin
            step(1, 1, 0, 100, 100, 100);
            check_lit("hold", 1, 18);
        end
        step(1, 1, 1, 100, 100, 100);
        check_lit("hold_release", 0, 18);
        group(1, 1, 0, 1, 0);
        check_lit("after_hold", 1, 9);
        step(1, 0, 1, 0, 0, 0);

        // Reset discards a partial group
        for (int i = 0; i < 4; i++) step(1, 1, 1, 7, 7, 0);
        step(0, 1, 1, 7, 7, 0);
        check_lit("reset_mid", 0, 0);
        step(0, 1, 1, 7, 7, 0);
        check_lit("reset_mid2", 0, 0);
        group(1, 1, 0, 1, 0);
        check_lit("after_reset", 1, 9);
        step(1, 0, 1, 0, 0, 0);

        // Back-to-back random groups with ready held high
        for (int i = 0; i < 10000; i++)
            step(1, 1, 1, int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 255)) - 128,
                 int'($urandom_range(0, 8192)) - 4096);

        // Random bubbles, backpressure and occasional reset
        for (int i = 0; i < 4000; i++)
            step(($urandom_range(0, 99) != 0), $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
                 int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 255)) - 128,
                 int'($urandom));

        @(negedge clk);
        checking = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
